retospect_cfg_loader: RTL and testbench

//  Byte-to-bitstream configuration sequencer for the neurochip config chain (clockbox + cnb array).

---
 rtl/retospect_cfg_loader_if.sv | 26 ++
 rtl/retospect_cfg_loader.sv | 150 +++++++++++++++
 tb/tb_retospect_cfg_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/retospect_cfg_loader_if.sv
// rtl/retospect_cfg_loader_if.sv - host/chain signal bundle for the config-chain loader
interface retospect_cfg_loader_if;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       config_en;
    logic       bs_in;
    logic       bs_ret;
    logic       reset_nn;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output start, abort, in_data, in_valid, bs_ret,
        input  in_ready, config_en, bs_in, reset_nn, busy, done, rd_data, rd_valid
    );

    modport slave (
        input  start, abort, in_data, in_valid, bs_ret,
        output in_ready, config_en, bs_in, reset_nn, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/retospect_cfg_loader.sv
// rtl/retospect_cfg_loader.sv - byte-to-bitstream config chain sequencer (optional readback: CFG_READBACK_EN)
module retospect_cfg_loader #(
    parameter  int CHAIN_LEN = 67,
    localparam int CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    retospect_cfg_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_NNRST} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_shreg;
    logic [7:0]      w_shreg_nxt;
    logic [2:0]      r_bit;
    logic [CW-1:0]   r_total;
    logic            w_last;
    logic            w_accept;

    logic r_in_ready, r_config_en, r_bs_in, r_reset_nn, r_busy, r_done;
    logic w_in_ready, w_config_en, w_bs_in, w_reset_nn, w_busy, w_done;

    assign w_last   = (r_total == CW'(CHAIN_LEN - 1));
    assign w_accept = bus.in_valid & r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_next = S_WAIT;
                S_WAIT:  if (w_accept)  w_next = S_SHIFT;
                S_SHIFT: begin
                    if (w_last)              w_next = S_NNRST;
                    else if (r_bit == 3'd7)  w_next = S_WAIT;
                end
                S_NNRST: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_shreg_nxt = r_shreg;
        if (r_state == S_WAIT && w_accept) w_shreg_nxt = bus.in_data;
        else if (r_state == S_SHIFT)       w_shreg_nxt = r_shreg >> 1;
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        w_in_ready  = (w_next == S_WAIT);
        w_config_en = (w_next == S_SHIFT);
        w_bs_in     = (w_next == S_SHIFT) ? w_shreg_nxt[0] : 1'b0;
        w_reset_nn  = (w_next == S_NNRST);
        w_done      = (w_next == S_NNRST);
        w_busy      = (w_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_config_en <= 1'b0;
            r_bs_in     <= 1'b0;
            r_reset_nn  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready;
            r_config_en <= w_config_en;
            r_bs_in     <= w_bs_in;
            r_reset_nn  <= w_reset_nn;
            r_done      <= w_done;
            r_busy      <= w_busy;
        end
    end

    // Abort freezes the counters; a fresh start clears the total anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= 8'd0;
            r_bit   <= 3'd0;
            r_total <= '0;
        end else if (!bus.abort) begin
            r_shreg <= w_shreg_nxt;
            case (r_state)
                S_IDLE:  if (bus.start) r_total <= '0;
                S_WAIT:  if (w_accept)  r_bit   <= 3'd0;
                S_SHIFT: begin
                    r_bit   <= r_bit + 3'd1;
                    r_total <= r_total + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.config_en = r_config_en;
    assign bus.bs_in     = r_bs_in;
    assign bus.reset_nn  = r_reset_nn;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;

`ifdef CFG_READBACK_EN
    logic [7:0] r_rd_acc;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic [7:0] w_rd_byte;

    assign w_rd_byte = r_rd_acc | (8'(bus.bs_ret) << r_bit);

    // The tail bit is captured on the same edge the chain shifts, so it is the bit leaving the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_acc   <= 8'd0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (bus.abort) begin
                r_rd_acc <= 8'd0;
            end else if (r_state == S_SHIFT) begin
                if (r_bit == 3'd7 || w_last) begin
                    r_rd_data  <= w_rd_byte;
                    r_rd_valid <= 1'b1;
                    r_rd_acc   <= 8'd0;
                end else begin
                    r_rd_acc   <= w_rd_byte;
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`else
    logic w_unused_bs_ret;
    assign w_unused_bs_ret = bus.bs_ret;
    assign bus.rd_data     = 8'd0;
    assign bus.rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// tb/tb_retospect_cfg_loader.sv - directed bench for retospect_cfg_loader with a 67-bit chain model
module tb_retospect_cfg_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retospect_cfg_loader_if bus();
    retospect_cfg_loader #(.CHAIN_LEN(67)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Chain model: bits enter at the head (bit 66) and leave at the tail (bit 0).
    logic [66:0] chain = '0;
    logic        pre_req = 1'b0;
    logic [66:0] pre_val = '0;
    always @(posedge clk) begin
        if (pre_req)             chain <= pre_val;
        else if (bus.config_en)  chain <= {bus.bs_in, chain[66:1]};
    end
    assign bus.bs_ret = chain[0];

    int   cyc = 0;
    int   n_en = 0, n_done = 0, n_nn = 0, n_rdv = 0, n_overlap = 0, n_dn_nn = 0, cyc_done = 0;
    logic       stream   [0:1023];
    logic [7:0] rd_bytes [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.config_en) begin
            stream[n_en[9:0]] <= bus.bs_in;
            n_en <= n_en + 1;
        end
        if (bus.done) begin
            n_done   <= n_done + 1;
            cyc_done <= cyc;
        end
        if (bus.reset_nn)                  n_nn      <= n_nn + 1;
        if (bus.done && bus.reset_nn)      n_dn_nn   <= n_dn_nn + 1;
        if (bus.config_en && bus.reset_nn) n_overlap <= n_overlap + 1;
        if (bus.rd_valid) begin
            rd_bytes[n_rdv[5:0]] <= bus.rd_data;
            n_rdv <= n_rdv + 1;
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed_byte(input logic [7:0] b, input logic noise, output bit ok);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            bus.start = noise;
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick(1);
        end
        bus.in_valid = 1'b0;
    endtask

    int res_en, res_err, res_lat, res_stall_bad, res_done, res_nn, res_to, res_busy_after;

    task automatic run_load(input logic [7:0] b, input int stall, input logic noise);
        int b_en, b_done, b_nn, cs;
        bit ok;
        b_en = n_en; b_done = n_done; b_nn = n_nn;
        res_to = 0; res_stall_bad = 0; res_err = 0;
        bus.start = 1'b1;
        cs = cyc;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            feed_byte(b, noise, ok);
            if (!ok) res_to++;
            if (i == 2 && stall > 0) begin
                for (int t = 0; t < 20 && bus.in_ready !== 1'b1; t++) tick(1);
                repeat (stall) begin
                    if (bus.config_en !== 1'b0) res_stall_bad++;
                    tick(1);
                end
            end
        end
        bus.start = 1'b0;
        for (int t = 0; t < 40 && n_done == b_done; t++) tick(1);
        if (n_done == b_done) res_to++;
        res_busy_after = {31'd0, bus.busy | bus.done};
        tick(2);
        res_en   = n_en - b_en;
        res_done = n_done - b_done;
        res_nn   = n_nn - b_nn;
        res_lat  = (res_done > 0) ? cyc_done - cs : -1;
        for (int i = 0; i < res_en; i++)
            if (stream[10'(b_en + i)] !== b[i % 8]) res_err++;
    endtask

    logic [66:0] exp_chain;
    logic [66:0] pv;
    logic [66:0] tmp;
    int b_en, b_done, b_nn, b_rdv;
    bit ok;

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_data = 8'd0; bus.in_valid = 1'b0;

        // Reset state
        tick(3);
        check("rst_busy",      bus.busy,      0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_config_en", bus.config_en, 0);
        check("rst_reset_nn",  bus.reset_nn,  0);
        check("rst_done",      bus.done,      0);
        check("rst_rd_valid",  bus.rd_valid,  0);
        rst_n = 1'b1;
        tick(2);

        // Async reset in the middle of a shift
        bus.start = 1'b1;
        tick(1);
        feed_byte(8'h3C, 1'b0, ok);
        tick(2);
        check("midrst_pre_en", bus.config_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en",    bus.config_en, 0);
        check("midrst_busy",  bus.busy,      0);
        check("midrst_bs_in", bus.bs_in,     0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("postrst_busy",     bus.busy,     0);
        check("postrst_in_ready", bus.in_ready, 0);

        // Full load of 9 x 0xA5, back-to-back
        run_load(8'hA5, 0, 1'b0);
        check("full_timeout",  res_to,   0);
        check("full_en_count", res_en,   67);
        check("full_bs_seq",   res_err,  0);
        check("full_done",     res_done, 1);
        check("full_reset_nn", res_nn,   1);
        check("full_latency",  res_lat,  77);
        check("full_busy_next", res_busy_after, 0);
        for (int i = 0; i < 67; i++) exp_chain[i] = (8'hA5 >> (i % 8)) & 8'h01;
        check("full_chain", chain, exp_chain);

        // 20-cycle input stall between bytes 3 and 4
        run_load(8'h1E, 20, 1'b0);
        check("stall_timeout",  res_to,        0);
        check("stall_en_low",   res_stall_bad, 0);
        check("stall_en_count", res_en,        67);
        check("stall_bs_seq",   res_err,       0);
        check("stall_done",     res_done,      1);

        // Abort after 30 shifted bits
        b_en = n_en; b_done = n_done; b_nn = n_nn; b_rdv = n_rdv;
        bus.start = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) feed_byte(8'h5A, 1'b0, ok);
        for (int t = 0; t < 40 && (n_en - b_en) < 30; t++) begin
            @(negedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy",   bus.busy,      0);
        check("abort_en",     bus.config_en, 0);
        tick(3);
        check("abort_en_count", n_en - b_en,     30);
        check("abort_no_done",  n_done - b_done, 0);
        check("abort_no_nn",    n_nn - b_nn,     0);
        check("abort_idle",     bus.in_ready,    0);
`ifdef CFG_READBACK_EN
        check("abort_rd_bytes", n_rdv - b_rdv, 3);
`else
        check("abort_rd_bytes", n_rdv - b_rdv, 0);
`endif
        run_load(8'hC3, 0, 1'b0);
        check("reload_en_count", res_en,   67);
        check("reload_bs_seq",   res_err,  0);
        check("reload_done",     res_done, 1);

        // start pulses during SHIFT and WAIT are ignored
        run_load(8'h96, 0, 1'b1);
        check("noise_timeout",  res_to,   0);
        check("noise_en_count", res_en,   67);
        check("noise_bs_seq",   res_err,  0);
        check("noise_done",     res_done, 1);

        // start and abort together in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("startabort_busy",  bus.busy,     0);
        check("startabort_ready", bus.in_ready, 0);
        tick(1);
        check("startabort_busy2", bus.busy,     0);

        // Readback of a preloaded chain while loading zeros
        pv = 67'h5_C3A5_0F96_1E2D_7B48;
        pre_val = pv;
        pre_req = 1'b1;
        tick(1);
        pre_req = 1'b0;
        b_rdv = n_rdv;
        run_load(8'h00, 0, 1'b0);
        check("rb_en_count", res_en, 67);
        check("rb_chain",    chain,  67'd0);
`ifdef CFG_READBACK_EN
        check("rb_count", n_rdv - b_rdv, 9);
        for (int k = 0; k < 9; k++) begin
            tmp = pv >> (8 * k);
            check($sformatf("rb_byte%0d", k), rd_bytes[6'(b_rdv + k)], tmp[7:0]);
        end
`else
        check("rb_count",   n_rdv - b_rdv, 0);
        check("rb_rd_data", bus.rd_data,   0);
`endif

        check("en_nn_overlap", n_overlap, 0);
        check("done_with_nn",  n_dn_nn,   n_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
